// File: rtl/cpu_ctrl_fsm_v2.sv
// Multicycle RV32I control unit: memory handshake, full branch set, jumps, LUI/AUIPC, sized accesses.
// Optional memory wait timeout with sticky bus_err when CPU_CTRL_MEM_TIMEOUT_EN is defined.
module cpu_ctrl_fsm_v2 #(
  parameter int unsigned ALU_OP_WIDTH   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              opc,
  input  logic [2:0]              funct3,
  input  logic [6:0]              funct7,
  input  logic                    z_flag,
  input  logic                    n_flag,
  input  logic                    c_flag,
  input  logic                    v_flag,
  input  logic                    mem_ready,
  output logic                    pc_wr_en,
  output logic                    mem_req,
  output logic                    mem_addr_src,
  output logic                    mem_wr_en,
  output logic [1:0]              mem_size,
  output logic                    instr_wr_en,
  output logic [1:0]              result_src,
  output logic [ALU_OP_WIDTH-1:0] alu_op_sel,
  output logic [1:0]              alu_a_src,
  output logic [1:0]              alu_b_src,
  output logic [2:0]              imd_src,
  output logic                    regfl_wr_en,
  output logic                    illegal_instr,
  output logic                    bus_err
);

  typedef enum logic [4:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH, S_JAL_T, S_JALR_A, S_JALR_T,
    S_LUI, S_AUIPC, S_HALT, S_BUS_ERR
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = ALU_OP_WIDTH'(0);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB  = ALU_OP_WIDTH'(1);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_AND  = ALU_OP_WIDTH'(2);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OR   = ALU_OP_WIDTH'(3);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR  = ALU_OP_WIDTH'(4);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL  = ALU_OP_WIDTH'(5);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL  = ALU_OP_WIDTH'(6);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA  = ALU_OP_WIDTH'(7);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLT  = ALU_OP_WIDTH'(8);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU = ALU_OP_WIDTH'(9);

  state_t state, state_next;
  logic   illegal_q;
  logic   br_taken_c, br_valid_c;
  logic   timeout_c;

  // alt selects SUB/SRA; callers mask it for I-type so ADDI never becomes SUB
  function automatic logic [ALU_OP_WIDTH-1:0] alu_decode(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_decode = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_decode = ALU_SLL;
      3'b010:  alu_decode = ALU_SLT;
      3'b011:  alu_decode = ALU_SLTU;
      3'b100:  alu_decode = ALU_XOR;
      3'b101:  alu_decode = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_decode = ALU_OR;
      default: alu_decode = ALU_AND;
    endcase
  endfunction

  // Branch condition from the flags of the rs1 - rs2 subtraction
  always_comb begin
    br_valid_c = 1'b1;
    br_taken_c = 1'b0;
    case (funct3)
      3'b000:  br_taken_c = z_flag;
      3'b001:  br_taken_c = !z_flag;
      3'b100:  br_taken_c = n_flag ^ v_flag;
      3'b101:  br_taken_c = !(n_flag ^ v_flag);
      3'b110:  br_taken_c = !c_flag;
      3'b111:  br_taken_c = c_flag;
      default: br_valid_c = 1'b0;
    endcase
  end

`ifdef CPU_CTRL_MEM_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt;
  logic       bus_err_q;
  logic       unused_bits;

  assign timeout_c   = !mem_ready && (wait_cnt == TIMEOUT_LAST);
  assign bus_err     = bus_err_q;
  assign unused_bits = ^{funct7[6], funct7[4:0]};

  // Wait counter restarts on every entry into a memory-waiting state
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt  <= 8'd0;
      bus_err_q <= 1'b0;
    end else begin
      if ((state_next != state) &&
          (state_next == S_FETCH || state_next == S_MEM_READ || state_next == S_MEM_WRITE))
        wait_cnt <= 8'd0;
      else if (!mem_ready &&
               (state == S_FETCH || state == S_MEM_READ || state == S_MEM_WRITE))
        wait_cnt <= wait_cnt + 8'd1;
      if (state_next == S_BUS_ERR)
        bus_err_q <= 1'b1;
    end
  end
`else
  logic unused_bits;
  assign timeout_c   = 1'b0;
  assign bus_err     = 1'b0;
  assign unused_bits = ^{funct7[6], funct7[4:0], 8'(TIMEOUT_CYCLES)};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next == S_HALT)
        illegal_q <= 1'b1;
    end
  end

  assign illegal_instr = illegal_q;

  always_comb begin
    state_next   = state;
    pc_wr_en     = 1'b0;
    mem_req      = 1'b0;
    mem_addr_src = 1'b0;
    mem_wr_en    = 1'b0;
    mem_size     = 2'b10;
    instr_wr_en  = 1'b0;
    result_src   = 2'b10;
    alu_op_sel   = ALU_ADD;
    alu_a_src    = 2'b00;
    alu_b_src    = 2'b00;
    imd_src      = 3'b000;
    regfl_wr_en  = 1'b0;
    case (state)
      S_FETCH: begin
        alu_b_src = 2'b10;
        if (!rst) begin
          mem_req = 1'b1;
          if (mem_ready) begin
            instr_wr_en = 1'b1;
            pc_wr_en    = 1'b1;
            state_next  = S_DECODE;
          end else if (timeout_c) begin
            state_next = S_BUS_ERR;
          end
        end
      end
      S_DECODE: begin
        alu_a_src = 2'b01;
        alu_b_src = 2'b01;
        imd_src   = (opc == OPC_JAL) ? 3'b011 : 3'b010;
        case (opc)
          OPC_LOAD, OPC_STORE: state_next = S_MEM_ADDR;
          OPC_R:               state_next = S_EXEC_R;
          OPC_I:               state_next = S_EXEC_I;
          OPC_BRANCH:          state_next = S_BRANCH;
          OPC_JAL:             state_next = S_JAL_T;
          OPC_JALR:            state_next = S_JALR_A;
          OPC_LUI:             state_next = S_LUI;
          OPC_AUIPC:           state_next = S_AUIPC;
          default:             state_next = S_HALT;
        endcase
      end
      S_MEM_ADDR: begin
        alu_a_src = 2'b10;
        alu_b_src = 2'b01;
        imd_src   = (opc == OPC_STORE) ? 3'b001 : 3'b000;
        mem_size  = funct3[1:0];
        if (funct3[1:0] == 2'b11)
          state_next = S_HALT;
        else
          state_next = (opc == OPC_STORE) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        mem_req      = 1'b1;
        mem_addr_src = 1'b1;
        mem_size     = funct3[1:0];
        if (mem_ready)      state_next = S_MEM_WB;
        else if (timeout_c) state_next = S_BUS_ERR;
      end
      S_MEM_WB: begin
        result_src  = 2'b01;
        regfl_wr_en = 1'b1;
        mem_size    = funct3[1:0];
        state_next  = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_req      = 1'b1;
        mem_wr_en    = 1'b1;
        mem_addr_src = 1'b1;
        mem_size     = funct3[1:0];
        if (mem_ready)      state_next = S_FETCH;
        else if (timeout_c) state_next = S_BUS_ERR;
      end
      S_EXEC_R: begin
        alu_a_src  = 2'b10;
        alu_op_sel = alu_decode(funct3, funct7[5]);
        state_next = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_a_src  = 2'b10;
        alu_b_src  = 2'b01;
        alu_op_sel = alu_decode(funct3, funct7[5] && (funct3 == 3'b101));
        state_next = S_ALU_WB;
      end
      S_ALU_WB: begin
        result_src  = 2'b00;
        regfl_wr_en = 1'b1;
        state_next  = S_FETCH;
      end
      S_BRANCH: begin
        alu_a_src  = 2'b10;
        alu_op_sel = ALU_SUB;
        result_src = 2'b00;
        if (br_valid_c) begin
          pc_wr_en   = br_taken_c;
          state_next = S_FETCH;
        end else begin
          state_next = S_HALT;
        end
      end
      // Jump target sits in ALUOut; ALU meanwhile forms old PC + 4 for rd
      S_JAL_T, S_JALR_T: begin
        pc_wr_en   = 1'b1;
        result_src = (state == S_JALR_T) ? 2'b11 : 2'b00;
        alu_a_src  = 2'b01;
        alu_b_src  = 2'b10;
        state_next = S_ALU_WB;
      end
      S_JALR_A: begin
        alu_a_src  = 2'b10;
        alu_b_src  = 2'b01;
        state_next = S_JALR_T;
      end
      S_LUI: begin
        alu_a_src  = 2'b11;
        alu_b_src  = 2'b01;
        imd_src    = 3'b100;
        state_next = S_ALU_WB;
      end
      S_AUIPC: begin
        alu_a_src  = 2'b01;
        alu_b_src  = 2'b01;
        imd_src    = 3'b100;
        state_next = S_ALU_WB;
      end
      S_HALT, S_BUS_ERR: state_next = state;
      default:           state_next = S_HALT;
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl_fsm_v2.sv
// Scoreboard bench for cpu_ctrl_fsm_v2: per-cycle expected control words queued by stimulus,
// popped and compared mid-cycle by an independent monitor.
module tb_cpu_ctrl_fsm_v2;

  typedef struct packed {
    logic       pc_wr_en;
    logic       mem_req;
    logic       mem_addr_src;
    logic       mem_wr_en;
    logic [1:0] mem_size;
    logic       instr_wr_en;
    logic [1:0] result_src;
    logic [3:0] alu_op_sel;
    logic [1:0] alu_a_src;
    logic [1:0] alu_b_src;
    logic [2:0] imd_src;
    logic       regfl_wr_en;
    logic       illegal_instr;
    logic       bus_err;
  } ctrl_t;

  typedef struct {
    ctrl_t exp;
    string tag;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opc = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic [6:0] funct7 = 7'd0;
  logic       z_flag = 1'b0, n_flag = 1'b0, c_flag = 1'b0, v_flag = 1'b0;
  logic       mem_ready = 1'b0;

  logic       pc_wr_en, mem_req, mem_addr_src, mem_wr_en, instr_wr_en, regfl_wr_en;
  logic       illegal_instr, bus_err;
  logic [1:0] mem_size, result_src, alu_a_src, alu_b_src;
  logic [3:0] alu_op_sel;
  logic [2:0] imd_src;
  ctrl_t      act;

  vec_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  cpu_ctrl_fsm_v2 dut (
    .clk(clk), .rst(rst), .opc(opc), .funct3(funct3), .funct7(funct7),
    .z_flag(z_flag), .n_flag(n_flag), .c_flag(c_flag), .v_flag(v_flag),
    .mem_ready(mem_ready), .pc_wr_en(pc_wr_en), .mem_req(mem_req),
    .mem_addr_src(mem_addr_src), .mem_wr_en(mem_wr_en), .mem_size(mem_size),
    .instr_wr_en(instr_wr_en), .result_src(result_src), .alu_op_sel(alu_op_sel),
    .alu_a_src(alu_a_src), .alu_b_src(alu_b_src), .imd_src(imd_src),
    .regfl_wr_en(regfl_wr_en), .illegal_instr(illegal_instr), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  assign act = {pc_wr_en, mem_req, mem_addr_src, mem_wr_en, mem_size, instr_wr_en,
                result_src, alu_op_sel, alu_a_src, alu_b_src, imd_src,
                regfl_wr_en, illegal_instr, bus_err};

  // Monitor: one queued expectation per cycle, checked away from the clock edge
  always @(negedge clk) begin
    vec_t v;
    if (q.size() != 0) begin
      v = q.pop_front();
      vectors++;
      if (act !== v.exp) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h", v.tag, act, v.exp);
      end
    end
  end

  // Hand-derived expected control words, one per state/condition
  function automatic ctrl_t e_dflt();
    ctrl_t c = '0;
    c.mem_size   = 2'b10;
    c.result_src = 2'b10;
    return c;
  endfunction
  function automatic ctrl_t e_rst();
    ctrl_t c = e_dflt(); c.alu_b_src = 2'b10; return c;
  endfunction
  function automatic ctrl_t e_fetch(input logic rdy);
    ctrl_t c = e_rst(); c.mem_req = 1'b1; c.instr_wr_en = rdy; c.pc_wr_en = rdy; return c;
  endfunction
  function automatic ctrl_t e_decode(input logic jal);
    ctrl_t c = e_dflt(); c.alu_a_src = 2'b01; c.alu_b_src = 2'b01;
    c.imd_src = jal ? 3'b011 : 3'b010; return c;
  endfunction
  function automatic ctrl_t e_exec(input logic [3:0] op, input logic imm);
    ctrl_t c = e_dflt(); c.alu_a_src = 2'b10; c.alu_b_src = imm ? 2'b01 : 2'b00;
    c.alu_op_sel = op; return c;
  endfunction
  function automatic ctrl_t e_alu_wb();
    ctrl_t c = e_dflt(); c.result_src = 2'b00; c.regfl_wr_en = 1'b1; return c;
  endfunction
  function automatic ctrl_t e_mem_addr(input logic st, input logic [1:0] sz);
    ctrl_t c = e_dflt(); c.alu_a_src = 2'b10; c.alu_b_src = 2'b01;
    c.imd_src = st ? 3'b001 : 3'b000; c.mem_size = sz; return c;
  endfunction
  function automatic ctrl_t e_mem_read();
    ctrl_t c = e_dflt(); c.mem_req = 1'b1; c.mem_addr_src = 1'b1; return c;
  endfunction
  function automatic ctrl_t e_mem_wb();
    ctrl_t c = e_dflt(); c.result_src = 2'b01; c.regfl_wr_en = 1'b1; return c;
  endfunction
  function automatic ctrl_t e_mem_write();
    ctrl_t c = e_mem_read(); c.mem_wr_en = 1'b1; return c;
  endfunction
  function automatic ctrl_t e_branch(input logic taken);
    ctrl_t c = e_dflt(); c.alu_a_src = 2'b10; c.alu_op_sel = 4'd1;
    c.result_src = 2'b00; c.pc_wr_en = taken; return c;
  endfunction
  function automatic ctrl_t e_jump_t(input logic jalr);
    ctrl_t c = e_dflt(); c.pc_wr_en = 1'b1; c.result_src = jalr ? 2'b11 : 2'b00;
    c.alu_a_src = 2'b01; c.alu_b_src = 2'b10; return c;
  endfunction
  function automatic ctrl_t e_ab_imm(input logic [1:0] a, input logic [2:0] imd);
    ctrl_t c = e_dflt(); c.alu_a_src = a; c.alu_b_src = 2'b01; c.imd_src = imd; return c;
  endfunction
  function automatic ctrl_t e_halt();
    ctrl_t c = e_dflt(); c.illegal_instr = 1'b1; return c;
  endfunction

  task automatic cyc(input logic r, input logic rdy, input string t, input ctrl_t e);
    vec_t v;
    rst = r; mem_ready = rdy;
    v.exp = e; v.tag = t;
    q.push_back(v);
    @(posedge clk); #1;
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
    opc = o; funct3 = f3; funct7 = f7;
  endtask

  task automatic run_alu(input string t, input logic [6:0] o, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [3:0] op, input logic imm);
    set_instr(o, f3, f7);
    cyc(0, 1, {t, "_fetch"},  e_fetch(1'b1));
    cyc(0, 1, {t, "_decode"}, e_decode(1'b0));
    cyc(0, 1, {t, "_exec"},   e_exec(op, imm));
    cyc(0, 1, {t, "_wb"},     e_alu_wb());
  endtask

  task automatic run_branch(input string t, input logic [2:0] f3, input logic [3:0] znvc,
                            input logic taken);
    set_instr(7'b1100011, f3, 7'd0);
    {z_flag, n_flag, v_flag, c_flag} = znvc;
    cyc(0, 1, {t, "_fetch"},  e_fetch(1'b1));
    cyc(0, 1, {t, "_decode"}, e_decode(1'b0));
    cyc(0, 1, {t, "_branch"}, e_branch(taken));
  endtask

  task automatic reset_from_halt(input string t);
    cyc(1, 1, {t, "_halt_rst"}, e_halt());
    cyc(1, 1, {t, "_rst"},      e_rst());
    cyc(0, 0, {t, "_refetch"},  e_fetch(1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    @(posedge clk); #1;
    cyc(1, 0, "reset0", e_rst());
    cyc(1, 1, "reset1", e_rst());
    cyc(0, 0, "release_fetch", e_fetch(1'b0));

    run_alu("add",   7'b0110011, 3'b000, 7'b0000000, 4'd0, 1'b0);
    run_alu("sub",   7'b0110011, 3'b000, 7'b0100000, 4'd1, 1'b0);
    run_alu("or",    7'b0110011, 3'b110, 7'b0000000, 4'd3, 1'b0);
    run_alu("sltu",  7'b0110011, 3'b011, 7'b0000000, 4'd9, 1'b0);
    run_alu("addi7", 7'b0010011, 3'b000, 7'b0100000, 4'd0, 1'b1);
    run_alu("srai",  7'b0010011, 3'b101, 7'b0100000, 4'd7, 1'b1);
    run_alu("slli",  7'b0010011, 3'b001, 7'b0000000, 4'd5, 1'b1);

    // LW with three wait states in MEM_READ: 8 cycles total
    set_instr(7'b0000011, 3'b010, 7'd0);
    cyc(0, 1, "lw_fetch",  e_fetch(1'b1));
    cyc(0, 1, "lw_decode", e_decode(1'b0));
    cyc(0, 1, "lw_addr",   e_mem_addr(1'b0, 2'b10));
    for (int i = 0; i < 3; i++) cyc(0, 0, "lw_wait", e_mem_read());
    cyc(0, 1, "lw_read", e_mem_read());
    cyc(0, 1, "lw_wb",   e_mem_wb());

    // SW, zero wait states: 4 cycles
    set_instr(7'b0100011, 3'b010, 7'd0);
    cyc(0, 1, "sw_fetch",  e_fetch(1'b1));
    cyc(0, 1, "sw_decode", e_decode(1'b0));
    cyc(0, 1, "sw_addr",   e_mem_addr(1'b1, 2'b10));
    cyc(0, 1, "sw_write",  e_mem_write());

    run_branch("blt_t",  3'b100, 4'b0100, 1'b1);
    run_branch("blt_nt", 3'b100, 4'b0110, 1'b0);
    run_branch("bgeu_t", 3'b111, 4'b0001, 1'b1);
    run_branch("bltu_nt",3'b110, 4'b0001, 1'b0);
    run_branch("beq_nt", 3'b000, 4'b0000, 1'b0);
    run_branch("bne_t",  3'b001, 4'b0000, 1'b1);

    set_instr(7'b1101111, 3'b000, 7'd0);
    cyc(0, 1, "jal_fetch",  e_fetch(1'b1));
    cyc(0, 1, "jal_decode", e_decode(1'b1));
    cyc(0, 1, "jal_t",      e_jump_t(1'b0));
    cyc(0, 1, "jal_wb",     e_alu_wb());

    set_instr(7'b1100111, 3'b000, 7'd0);
    cyc(0, 1, "jalr_fetch",  e_fetch(1'b1));
    cyc(0, 1, "jalr_decode", e_decode(1'b0));
    cyc(0, 1, "jalr_a",      e_ab_imm(2'b10, 3'b000));
    cyc(0, 1, "jalr_t",      e_jump_t(1'b1));
    cyc(0, 1, "jalr_wb",     e_alu_wb());

    set_instr(7'b0110111, 3'b000, 7'd0);
    cyc(0, 1, "lui_fetch",  e_fetch(1'b1));
    cyc(0, 1, "lui_decode", e_decode(1'b0));
    cyc(0, 1, "lui_exec",   e_ab_imm(2'b11, 3'b100));
    cyc(0, 1, "lui_wb",     e_alu_wb());

    set_instr(7'b0010111, 3'b000, 7'd0);
    cyc(0, 1, "auipc_fetch",  e_fetch(1'b1));
    cyc(0, 1, "auipc_decode", e_decode(1'b0));
    cyc(0, 1, "auipc_exec",   e_ab_imm(2'b01, 3'b100));
    cyc(0, 1, "auipc_wb",     e_alu_wb());

    // Store abandoned by reset after long wait; no bus_err without the timeout feature
    set_instr(7'b0100011, 3'b010, 7'd0);
    cyc(0, 1, "swr_fetch",  e_fetch(1'b1));
    cyc(0, 1, "swr_decode", e_decode(1'b0));
    cyc(0, 1, "swr_addr",   e_mem_addr(1'b1, 2'b10));
    for (int i = 0; i < 10; i++) cyc(0, 0, "swr_wait", e_mem_write());
    cyc(1, 0, "swr_rst",     e_mem_write());
    cyc(0, 0, "swr_dropped", e_fetch(1'b0));

    // Illegal opcode halts and ignores mem_ready until reset
    set_instr(7'b1111111, 3'b000, 7'd0);
    cyc(0, 1, "ill_fetch",  e_fetch(1'b1));
    cyc(0, 1, "ill_decode", e_decode(1'b0));
    for (int i = 0; i < 3; i++) cyc(0, 1, "ill_halt", e_halt());
    reset_from_halt("ill");

    // Load with funct3[1:0]=11 halts from MEM_ADDR
    set_instr(7'b0000011, 3'b011, 7'd0);
    cyc(0, 1, "ld_fetch",  e_fetch(1'b1));
    cyc(0, 1, "ld_decode", e_decode(1'b0));
    cyc(0, 1, "ld_addr",   e_mem_addr(1'b0, 2'b11));
    cyc(0, 1, "ld_halt",   e_halt());
    reset_from_halt("ld");

    // Branch funct3 010 halts without writing the PC
    run_branch("bbad", 3'b010, 4'b1111, 1'b0);
    cyc(0, 1, "bbad_halt", e_halt());
    reset_from_halt("bbad");

    @(negedge clk); #1;
    if (q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl_fsm_v2.md
Name: cpu_ctrl_fsm_v2

Overview:
- Second-generation multicycle RV32I control unit FSM. Drives the program counter, the instruction/data memory, the register file, the sign-extension unit and the ALU of the multicycle core.
- Over the first-generation control unit it adds:
  - a memory request/ready handshake with unbounded wait states;
  - all six branch conditions, derived from ALU flags;
  - JAL, JALR, LUI, AUIPC;
  - byte/half/word access size;
  - an illegal-instruction halt state.

Parameters:
- ALU_OP_WIDTH, 4, width of alu_op_sel.
- TIMEOUT_CYCLES, 64, memory wait limit. Used only when CPU_CTRL_MEM_TIMEOUT_EN is defined; legal range 2..255.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- opc  in  7  instruction opcode.
- funct3  in  3  instruction funct3.
- funct7  in  7  instruction funct7; only bit 5 is used.
- z_flag, n_flag, c_flag, v_flag  in  1 each  ALU flags from the current cycle.
  - c_flag is 1 when in_a >= in_b unsigned on SUB (no borrow).
- mem_ready  in  1  memory completes the pending request this cycle.
- pc_wr_en  out  1  load PC.
- mem_req  out  1  memory access request.
- mem_addr_src  out  1  memory address select: 0 = PC, 1 = ALU result register (ALUOut).
- mem_wr_en  out  1  memory write.
- mem_size  out  2  access size: 00 byte, 01 half, 10 word.
- instr_wr_en  out  1  latch the instruction and the old PC.
- result_src  out  2  result select:
  - 00 = ALUOut;
  - 01 = memory read data;
  - 10 = ALU result (combinational);
  - 11 = ALUOut with bit 0 cleared.
- alu_op_sel  out  ALU_OP_WIDTH  ALU operation:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR;
  - 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU.
- alu_a_src  out  2  ALU input A: 00 PC, 01 old PC, 10 rd1, 11 zero.
- alu_b_src  out  2  ALU input B: 00 rd2, 01 immediate, 10 constant 4.
- imd_src  out  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U.
- regfl_wr_en  out  1  register file write.
- illegal_instr  out  1  sticky; set on entry to HALT.
- bus_err  out  1  sticky; only present with the macro, otherwise tied to 0.

Behaviour:
- Reset: the state register goes to FETCH on the first rising clk edge with rst=1; illegal_instr and bus_err clear.
  - All outputs are Moore functions of state, except pc_wr_en, instr_wr_en and the branch qualification.
  - In FETCH while rst=1, all enables are 0.
- Default output values in every state: every enable 0, alu_op_sel=ADD, result_src=10, mem_size=10, all selects 00.
- FETCH:
  - Drives mem_req=1, mem_addr_src=0, alu_a_src=00, alu_b_src=10, alu_op_sel=ADD.
  - Stays in FETCH while mem_ready=0.
  - When mem_ready=1 in the same cycle: instr_wr_en=1, pc_wr_en=1 (PC+4), and the next state is DECODE.
- DECODE: alu_a_src=01, alu_b_src=01, imd_src=010, ADD, so ALUOut = old PC + B-immediate. Next state by opcode:
  - 0000011 -> MEM_ADDR (load)
  - 0100011 -> MEM_ADDR (store)
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 1100011 -> BRANCH
  - 1101111 -> JAL_T (imd_src=011 used instead)
  - 1100111 -> JALR_A
  - 0110111 -> LUI
  - 0010111 -> AUIPC
  - any other opcode -> HALT
- MEM_ADDR:
  - Drives alu_a_src=10, alu_b_src=01, ADD; imd_src=000 for loads, 001 for stores.
  - Next state MEM_READ for loads, MEM_WRITE for stores.
  - funct3 selects mem_size (funct3[1:0]). funct3[1:0]=11 goes to HALT.
- MEM_READ: mem_req=1, mem_addr_src=1; waits on mem_ready, then goes to MEM_WB.
- MEM_WB: result_src=01, regfl_wr_en=1; next state FETCH.
- MEM_WRITE:
  - Drives mem_req=1, mem_wr_en=1, mem_addr_src=1.
  - Holds while mem_ready=0; goes to FETCH when mem_ready=1.
- EXEC_R:
  - Drives alu_a_src=10, alu_b_src=00; alu_op_sel is decoded from funct3 and funct7[5].
  - funct7[5] selects SUB for funct3 000 and SRA for funct3 101.
  - Next state ALU_WB.
- EXEC_I:
  - Same as EXEC_R but alu_b_src=01, imd_src=000.
  - funct7[5] is honoured only for funct3 101 (SRAI); ADDI never decodes to SUB.
- ALU_WB: result_src=00, regfl_wr_en=1; next state FETCH.
- BRANCH:
  - Drives alu_a_src=10, alu_b_src=00, SUB, result_src=00.
  - pc_wr_en = taken, where taken is decoded from funct3:
    - 000: z
    - 001: !z
    - 100: n^v
    - 101: !(n^v)
    - 110: !c
    - 111: c
  - funct3 010 or 011 goes to HALT with pc_wr_en=0.
  - Otherwise the next state is FETCH.
- JAL_T: pc_wr_en=1, result_src=00, alu_a_src=01, alu_b_src=10, ADD; next state ALU_WB (rd = old PC + 4).
- JALR_A: alu_a_src=10, alu_b_src=01, imd_src=000, ADD; next state JALR_T.
- JALR_T: same as JAL_T but result_src=11.
- LUI: alu_a_src=11, alu_b_src=01, imd_src=100, ADD; next state ALU_WB.
- AUIPC: alu_a_src=01, alu_b_src=01, imd_src=100, ADD; next state ALU_WB.
- HALT: sets illegal_instr, all enables 0, absorbing state; only rst exits.
- Wait states:
  - mem_req stays high and all other outputs stay stable until mem_ready is sampled high.
  - mem_ready outside FETCH, MEM_READ and MEM_WRITE is ignored.
- Reset mid-operation: rst has priority over every transition. A write in progress is abandoned: mem_wr_en drops to 0 in the cycle after rst is sampled.
- Minimum cycle counts (mem_ready=1 always):
  - R/I/JAL/LUI/AUIPC: 4
  - JALR: 5
  - load: 5
  - store: 4
  - branch: 3

Optional Feature:
- CPU_CTRL_MEM_TIMEOUT_EN defined:
  - An 8-bit wait counter clears on entry to FETCH, MEM_READ and MEM_WRITE, and increments each cycle mem_ready=0.
  - When the count reaches TIMEOUT_CYCLES-1 with mem_ready still 0, the FSM goes to BUS_ERR, sets bus_err, and drops mem_req.
  - BUS_ERR is absorbing, like HALT.
- Undefined: no counter; bus_err is constant 0; waits are unbounded.

Test Plan:
- Reset: rst=1 for 2 cycles -> state FETCH, mem_req=0, illegal_instr=0; release -> mem_req=1 and mem_addr_src=0 the next cycle.
- ADD (opc 0110011, funct3 000, funct7 0000000) with mem_ready=1 -> exactly 4 cycles. EXEC_R alu_op_sel=0; ALU_WB regfl_wr_en=1 for one cycle. Same with funct7 0100000 -> alu_op_sel=1.
- LW with mem_ready held low for 3 cycles in MEM_READ -> mem_req=1 and mem_addr_src=1 held stable for 4 cycles; MEM_WB follows with result_src=01 and regfl_wr_en=1; total 8 cycles.
- BLT (funct3 100) with n=1,v=0 -> pc_wr_en=1 in BRANCH. With n=1,v=1 -> pc_wr_en=0. BGEU with c=1 -> pc_wr_en=1.
- JALR -> JALR_T asserts pc_wr_en=1 with result_src=11; the next cycle ALU_WB writes the register. Opcode 1111111 -> HALT with illegal_instr=1 held until rst.
- With the macro and TIMEOUT_CYCLES=4, SW with mem_ready=0 forever -> bus_err=1 after 4 MEM_WRITE cycles and mem_req=0. Without the macro -> it waits indefinitely and bus_err=0.
